// File: rtl/ad7357_driver.sv
`default_nettype none
// ============================================================================
// Module   : ad7357_driver
// Function : AD7357 conversion sequencer and dual-lane serial receiver.
// Revision : 1.0
// ============================================================================
module ad7357_driver #(
    parameter int unsigned CAPTURE_LAT = 3,
    parameter int unsigned TCS_SETUP   = 1,
    parameter int unsigned TQUIET      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_ctl_cken,
    output logic        o_adc_cs_n,
    input  logic        i_adc_sdata_a,
    input  logic        i_adc_sdata_b,
    output logic [13:0] o_data_a,
    output logic [13:0] o_data_b,
    output logic        o_valid,
    output logic        o_err_lead
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CS_SETUP = 2'd1,
        S_CLOCKING = 2'd2,
        S_QUIET    = 2'd3
    } state_t;

    localparam int unsigned c_end_int    = (CAPTURE_LAT > 0) ? CAPTURE_LAT + 15 : 15;
    localparam logic [5:0]  c_cnt_end    = 6'(c_end_int);
    localparam logic [5:0]  c_cap_lat    = 6'(CAPTURE_LAT);
    localparam logic [5:0]  c_cs_last    = 6'(TCS_SETUP - 1);
    localparam logic [5:0]  c_quiet_last = 6'(TQUIET - 1);
    localparam logic [5:0]  c_sclk_cnt   = 6'd16;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [15:0] r_shift_a;
    logic [15:0] r_shift_b;

    state_t      w_state_nxt;
    logic [5:0]  w_cnt_nxt;
    logic [5:0]  w_cap_idx;
    logic        w_capture;
    logic        w_done;
    logic [15:0] w_shift_a_nxt;
    logic [15:0] w_shift_b_nxt;
    logic        w_busy_nxt;
    logic        w_cs_n_nxt;
    logic        w_cken_nxt;
    logic        w_err_nxt;

    // Before the window r_cnt - CAPTURE_LAT wraps to >= 33, so one compare bounds both ends.
    assign w_cap_idx     = r_cnt - c_cap_lat;
    assign w_capture     = (r_state == S_CLOCKING) && (w_cap_idx < c_sclk_cnt);
    assign w_shift_a_nxt = w_capture ? {r_shift_a[14:0], i_adc_sdata_a} : r_shift_a;
    assign w_shift_b_nxt = w_capture ? {r_shift_b[14:0], i_adc_sdata_b} : r_shift_b;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 6'd1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (i_start) begin
                    w_state_nxt = S_CS_SETUP;
                end
            end
            S_CS_SETUP: begin
                if (r_cnt == c_cs_last) begin
                    w_state_nxt = S_CLOCKING;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLOCKING: begin
                if (r_cnt == c_cnt_end) begin
                    w_state_nxt = S_QUIET;
                    w_cnt_nxt   = '0;
                    w_done      = 1'b1;
                end
            end
            S_QUIET: begin
                if (r_cnt == c_quiet_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_cs_n_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_QUIET);
        w_cken_nxt = (w_state_nxt == S_CLOCKING) && (w_cnt_nxt < c_sclk_cnt);
        w_err_nxt  = w_done && ((|w_shift_a_nxt[15:14]) || (|w_shift_b_nxt[15:14]));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shift_a  <= '0;
            r_shift_b  <= '0;
            o_busy     <= 1'b0;
            o_adc_cs_n <= 1'b1;
            o_ctl_cken <= 1'b0;
            o_valid    <= 1'b0;
            o_err_lead <= 1'b0;
            o_data_a   <= '0;
            o_data_b   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift_a  <= w_shift_a_nxt;
            r_shift_b  <= w_shift_b_nxt;
            o_busy     <= w_busy_nxt;
            o_adc_cs_n <= w_cs_n_nxt;
            o_ctl_cken <= w_cken_nxt;
            o_valid    <= w_done;
            o_err_lead <= w_err_nxt;
            // The last bit lands on the same edge, so publish the next-shift value.
            if (w_done) begin
                o_data_a <= w_shift_a_nxt[13:0];
                o_data_b <= w_shift_b_nxt[13:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ad7357_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad7357_driver
// Function : Randomised self-checking bench, four parameter sets side by side.
// Revision : 1.0
// ============================================================================
module tb_ad7357_driver;

    localparam int NI   = 4;
    localparam int NCYC = 3000;

    function automatic int cfg_lat(input int i);
        case (i)
            1:       return 20;
            3:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_tcs(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic int cfg_tq(input int i);
        case (i)
            2:       return 5;
            3:       return 1;
            default: return 2;
        endcase
    endfunction

    // Hand-computed start-to-start periods for each parameter set.
    function automatic int cfg_period(input int i);
        case (i)
            0:       return 23;
            1:       return 40;
            2:       return 28;
            default: return 19;
        endcase
    endfunction

    function automatic int clk_len(input int i);
        return (cfg_lat(i) > 0) ? cfg_lat(i) + 16 : 16;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [NI];
    logic        start_v [NI];
    logic        sda_v   [NI];
    logic        sdb_v   [NI];
    logic        busy_v  [NI];
    logic        cken_v  [NI];
    logic        cs_v    [NI];
    logic        valid_v [NI];
    logic        err_v   [NI];
    logic [13:0] da_v    [NI];
    logic [13:0] db_v    [NI];

    logic [15:0] cur_wa [NI];
    logic [15:0] cur_wb [NI];
    bit          rst_fired [NI];
    bit          bb_phase = 1'b0;
    bit          done_f   = 1'b0;

    int total = 0;
    int bad   = 0;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        ad7357_driver #(
            .CAPTURE_LAT (cfg_lat(gi)),
            .TCS_SETUP   (cfg_tcs(gi)),
            .TQUIET      (cfg_tq(gi))
        ) u_dut (
            .i_clk         (clk),
            .i_rst         (rst_v[gi]),
            .i_start       (start_v[gi]),
            .o_busy        (busy_v[gi]),
            .o_ctl_cken    (cken_v[gi]),
            .o_adc_cs_n    (cs_v[gi]),
            .i_adc_sdata_a (sda_v[gi]),
            .i_adc_sdata_b (sdb_v[gi]),
            .o_data_a      (da_v[gi]),
            .o_data_b      (db_v[gi]),
            .o_valid       (valid_v[gi]),
            .o_err_lead    (err_v[gi])
        );
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    // Stimulus and ADC model: the ADC shifts out its word on SCLK falling edges,
    // so bit k appears CAPTURE_LAT+k cycles after SCLK starts running.
    initial begin : p_drive
        int j        [NI];
        bit prev_ck  [NI];
        int rst_hold [NI];
        bit rst_arm  [NI];
        int k;
        for (int i = 0; i < NI; i++) begin
            rst_v[i]     = 1'b1;
            start_v[i]   = 1'b0;
            sda_v[i]     = 1'b0;
            sdb_v[i]     = 1'b0;
            j[i]         = 100;
            prev_ck[i]   = 1'b0;
            rst_hold[i]  = 0;
            rst_arm[i]   = 1'b0;
            rst_fired[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            bb_phase = (c >= 300) && (c < 700);
            for (int i = 0; i < NI; i++) begin
                if (cken_v[i] && !prev_ck[i]) j[i] = 0;
                else if (j[i] < 100) j[i]++;
                prev_ck[i] = cken_v[i];
                k = j[i] - cfg_lat(i);
                if (k >= 0 && k < 16) begin
                    sda_v[i] = cur_wa[i][15-k];
                    sdb_v[i] = cur_wb[i][15-k];
                end else begin
                    sda_v[i] = 1'($urandom);
                    sdb_v[i] = 1'($urandom);
                end
                if (c == 700) rst_arm[i] = 1'b1;
                if (rst_hold[i] > 0) begin
                    rst_hold[i]--;
                    if (rst_hold[i] == 0) rst_v[i] = 1'b0;
                end else if (rst_arm[i] && cken_v[i] && j[i] == 8) begin
                    rst_v[i]     = 1'b1;
                    rst_hold[i]  = 2;
                    rst_arm[i]   = 1'b0;
                    rst_fired[i] = 1'b1;
                end
                if (bb_phase)                  start_v[i] = 1'b1;
                else if (c >= 700 && c < 1200) start_v[i] = ($urandom_range(2) == 0);
                else                           start_v[i] = ($urandom_range(5) == 0);
            end
        end
        done_f = 1'b1;
    end

    // Reference model: r counts cycles since the accepting edge (0 = idle);
    // every output follows from where r sits in the conversion timeline.
    initial begin : p_check
        int r        [NI];
        int conv_id  [NI];
        int n_acc    [NI];
        int n_valid  [NI];
        int ck_run   [NI];
        int last_v   [NI];
        bit have_bb  [NI];
        logic [15:0] wa [NI];
        logic [15:0] wb [NI];
        logic [13:0] exp_da [NI];
        logic [13:0] exp_db [NI];
        int ncyc, tcs, len, tq;
        bit e_busy, e_cs, e_ck, e_valid, e_err;
        ncyc = 0;
        for (int i = 0; i < NI; i++) begin
            r[i] = 0; conv_id[i] = 0; n_acc[i] = 0; n_valid[i] = 0; ck_run[i] = 0;
            last_v[i] = 0; have_bb[i] = 1'b0; wa[i] = '0; wb[i] = '0;
            exp_da[i] = '0; exp_db[i] = '0; cur_wa[i] = '0; cur_wb[i] = '0;
        end
        while (!done_f) begin
            @(negedge clk);
            ncyc++;
            for (int i = 0; i < NI; i++) begin
                tcs = cfg_tcs(i);
                len = clk_len(i);
                tq  = cfg_tq(i);
                if (rst_v[i]) begin
                    r[i] = 0; exp_da[i] = '0; exp_db[i] = '0; ck_run[i] = 0;
                    e_busy = 0; e_cs = 1; e_ck = 0; e_valid = 0; e_err = 0;
                end else begin
                    e_busy  = (r[i] != 0);
                    e_cs    = !(r[i] >= 1 && r[i] <= tcs + len);
                    e_ck    = (r[i] >= tcs + 1) && (r[i] <= tcs + 16);
                    e_valid = (r[i] == tcs + len + 1);
                    e_err   = 0;
                    if (e_valid) begin
                        exp_da[i] = wa[i][13:0];
                        exp_db[i] = wb[i][13:0];
                        e_err     = (wa[i][15:14] != 2'b00) || (wb[i][15:14] != 2'b00);
                    end
                end
                if (cken_v[i] === 1'b1) ck_run[i]++;
                chk("busy",     i, busy_v[i],  e_busy);
                chk("cs_n",     i, cs_v[i],    e_cs);
                chk("cken",     i, cken_v[i],  e_ck);
                chk("valid",    i, valid_v[i], e_valid);
                chk("err_lead", i, err_v[i],   e_err);
                chk("data_a",   i, da_v[i],    exp_da[i]);
                chk("data_b",   i, db_v[i],    exp_db[i]);
                if (e_valid) begin
                    n_valid[i]++;
                    chk("cken_len", i, ck_run[i], 16);
                    ck_run[i] = 0;
                    if (i == 0 && conv_id[i] == 0) begin
                        chk("lit_a0",   i, da_v[i],  14'h2A5C);
                        chk("lit_b0",   i, db_v[i],  14'h15A3);
                        chk("lit_err0", i, err_v[i], 1'b0);
                    end
                    if (i == 0 && conv_id[i] == 1) begin
                        chk("lit_a1",   i, da_v[i],  14'h3FFF);
                        chk("lit_err1", i, err_v[i], 1'b1);
                    end
                    if (i == 1 && conv_id[i] == 0) begin
                        chk("lit_lat_a", i, da_v[i], 14'h0001);
                        chk("lit_lat_b", i, db_v[i], 14'h0001);
                    end
                    if (bb_phase) begin
                        if (have_bb[i]) chk("period", i, ncyc - last_v[i], cfg_period(i));
                        have_bb[i] = 1'b1;
                        last_v[i]  = ncyc;
                    end else begin
                        have_bb[i] = 1'b0;
                    end
                end
                if (!rst_v[i]) begin
                    if (r[i] == 0) begin
                        if (start_v[i]) begin
                            r[i] = 1;
                            if (i == 0 && n_acc[i] == 0) begin
                                wa[i] = 16'h2A5C; wb[i] = 16'h15A3;
                            end else if (i == 0 && n_acc[i] == 1) begin
                                wa[i] = 16'h3FFF; wb[i] = 16'h4123;
                            end else if (i == 1 && n_acc[i] == 0) begin
                                wa[i] = 16'h0001; wb[i] = 16'h0001;
                            end else begin
                                wa[i] = 16'($urandom);
                                wb[i] = 16'($urandom);
                                if ($urandom_range(3) != 0) wa[i][15:14] = 2'b00;
                                if ($urandom_range(3) != 0) wb[i][15:14] = 2'b00;
                            end
                            cur_wa[i]  = wa[i];
                            cur_wb[i]  = wb[i];
                            conv_id[i] = n_acc[i];
                            n_acc[i]++;
                        end
                    end else if (r[i] == tcs + len + tq) begin
                        r[i] = 0;
                    end else begin
                        r[i]++;
                    end
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk("reset_at_cnt8_reached", i, rst_fired[i], 1'b1);
            chk("enough_valids", i, (n_valid[i] >= 5), 1'b1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ad7357_driver.md
Name: ad7357_driver

Overview:
- Conversion sequencer and serial receiver for one AD7357 dual-channel 14-bit ADC.
- On a start strobe it:
  - drives CS low;
  - requests SCLK from the shared SCLK generator via o_ctl_cken, for exactly 16 SCLK periods;
  - shifts in SDATAA/SDATAB;
  - presents both 14-bit samples with a one-cycle valid strobe.
- Several instances may share one SCLK generator; their cken outputs are ORed externally.

Parameters:
- CAPTURE_LAT, 3: i_clk cycles from the first cken-high cycle to the capture of bit 0 (leading zero). Covers SCLK generator, DDR and input-register latency. Range 0..31.
- TCS_SETUP, 1: cycles CS is held low before cken is first asserted. Range 1..15.
- TQUIET, 2: minimum cycles CS is held high after a conversion before the next start is accepted. Range 1..15.

Ports:
- i_clk  in  1  system clock; SCLK = ~i_clk while enabled
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  conversion request pulse; honoured only in IDLE
- o_busy  out  1  high in every state except IDLE
- o_ctl_cken  out  1  SCLK enable request to the SCLK generator (registered)
- o_adc_cs_n  out  1  AD7357 CS, active-low (registered)
- i_adc_sdata_a  in  1  SDATAA, already registered in the IOB
- i_adc_sdata_b  in  1  SDATAB, already registered in the IOB
- o_data_a  out  14  last channel A sample
- o_data_b  out  14  last channel B sample
- o_valid  out  1  one-cycle strobe; o_data_* updated in the same cycle
- o_err_lead  out  1  valid with o_valid; high if either channel's 2 leading bits were not 00

Behaviour:
- Reset (async, any state):
  - state IDLE; o_adc_cs_n=1; o_ctl_cken=0.
  - o_valid=0; o_err_lead=0; o_busy=0.
  - o_data_a=o_data_b=0; counters and shift registers cleared.
- Reset mid-conversion aborts immediately; no o_valid is produced for the aborted conversion.
- All outputs are registered. State machine:
  - IDLE: o_adc_cs_n=1. If i_start=1 -> CS_SETUP; o_adc_cs_n=0 from the next cycle. i_start in any other state is ignored (not queued).
  - CS_SETUP: stays TCS_SETUP cycles with CS low, then -> CLOCKING.
  - CLOCKING: cycle counter cnt starts at 0 on entry and increments every cycle.
    - o_ctl_cken=1 for cnt 0..15 exactly (16 cycles), then 0.
    - Capture when CAPTURE_LAT <= cnt <= CAPTURE_LAT+15: shift i_adc_sdata_a and i_adc_sdata_b into separate 16-bit registers, MSB first (first captured bit ends up at bit 15).
    - When cnt = max(15, CAPTURE_LAT+15) -> QUIET. CS stays low until then, so it stays low across the capture tail when CAPTURE_LAT > 0.
  - QUIET: o_adc_cs_n=1 from the first QUIET cycle; hold TQUIET cycles -> IDLE.
    - In the first QUIET cycle: o_valid=1; o_data_a=shift_a[13:0]; o_data_b=shift_b[13:0]; o_err_lead = |shift_a[15:14] | |shift_b[15:14].
- o_valid and o_err_lead are 0 in every other cycle.
- o_data_* hold their value between conversions.
- o_busy=0 only in IDLE.
- Back-to-back starts: minimum start-to-start period = 1 + TCS_SETUP + max(16, CAPTURE_LAT+16) + TQUIET cycles.
- cnt width is 6 bits; cnt never wraps within legal parameter ranges.
- A start asserted in the same cycle as the return to IDLE is not seen; it must arrive while o_busy=0.

Test Plan:
- Defaults; pulse i_start; ADC model outputs 00 + 14'h2A5C on A and 00 + 14'h15A3 on B, changing data on SCLK falling edges.
  -> o_ctl_cken high exactly 16 cycles, 1 cycle after CS falls.
  -> o_valid single pulse with o_data_a=14'h2A5C, o_data_b=14'h15A3, o_err_lead=0.
  -> CS high 2 cycles before o_busy=0.
- Model drives leading bits 01 on B, A=14'h3FFF.
  -> o_valid with o_data_a=14'h3FFF, o_err_lead=1.
- i_start pulsed every cycle continuously.
  -> conversions exactly 1+1+19+2=23 cycles apart; no start accepted while o_busy=1.
- CAPTURE_LAT=20.
  -> cken still 16 cycles; CS low until cnt=35.
  -> data captured correctly, e.g. 14'h0001 on both channels.
- Assert i_rst at cnt=8 of CLOCKING.
  -> same cycle: CS=1, cken=0, o_busy=0; no o_valid.
  -> next i_start after release yields a correct sample.
- TCS_SETUP=3, TQUIET=5.
  -> 3 cycles of CS low before the first cken cycle; CS high ≥5 cycles between conversions.
